stream_scheduler: RTL and testbench

Generates the per-symbol transfer-unit (TU) schedule for the main-stream symbol path. The schedule covers 64-symbol TUs: valid data symbols first, then stuffing bracketed by FS/FE control symbols. The block drives `sched_stream_en`/`sched_stream_state` directly into the active symbol mapper stage, and pops the steering buffer via `sched_main_rd`. A fractional accumulator spreads non-integer data rates across successive TUs.

---
 rtl/dp_sched_pkg.sv | 32 +++
 rtl/tu_frac_accum.sv | 50 +++++
 rtl/stream_scheduler.sv | 125 ++++++++++++
 tb/tb_stream_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dp_sched_pkg.sv
// Shared types for the main-stream symbol scheduler and the symbol mapper.
package dp_sched_pkg;

  localparam int TU_SIZE = 64;

  typedef enum logic [1:0] {
    SS_FS    = 2'b00,
    SS_FE    = 2'b01,
    SS_DATA  = 2'b10,
    SS_STUFF = 2'b11
  } stream_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_FS,
    ST_STUFF,
    ST_FE
  } sched_fsm_t;

  // Valid data size is 1..64; 0 means 1, anything above 64 saturates.
  function automatic logic [6:0] clamp_size(input logic [6:0] size);
    if (size == 7'd0) begin
      return 7'd1;
    end else if (size > 7'(TU_SIZE)) begin
      return 7'(TU_SIZE);
    end else begin
      return size;
    end
  endfunction

endpackage

// File: rtl/tu_frac_accum.sv
// Fractional data-size accumulator: yields the per-TU data symbol count N,
// captured at each TU start so mid-TU config changes are ignored.
module tu_frac_accum
  import dp_sched_pkg::*;
#(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [6:0]        size_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic [6:0]        n_o
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] base;
  logic [FRAC_W:0]   sum;
  logic [6:0]        n_raw;
  logic [6:0]        n_q, n_d;

  always_comb begin
    base  = clear_i ? '0 : acc_q;
    sum   = {1'b0, base} + {1'b0, frac_i};
    // The carry can push a 64-symbol TU to 65; saturate back to a full TU.
    n_raw = clamp_size(size_i) + {6'd0, sum[FRAC_W]};
    n_d   = n_q;
    acc_d = acc_q;
    if (advance_i) begin
      acc_d = sum[FRAC_W-1:0];
      n_d   = (n_raw > 7'(TU_SIZE)) ? 7'(TU_SIZE) : n_raw;
    end else if (clear_i) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      n_q   <= 7'd1;
    end else begin
      acc_q <= acc_d;
      n_q   <= n_d;
    end
  end

  assign n_o = n_q;

endmodule

// File: rtl/stream_scheduler.sv
// Per-symbol transfer-unit scheduler: DATA slots first, then FS/STUFF/FE.
//   state    | meaning
//   ST_IDLE  | no TU active, outputs deasserted, waiting for sched_go
//   ST_DATA  | main data slot, pops the steering buffer
//   ST_FS    | fill-start control symbol at pos N
//   ST_STUFF | stuffing between FS and FE
//   ST_FE    | fill-end control symbol at pos 63
module stream_scheduler #(
  parameter int TU_SIZE = 64,
  parameter int FRAC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sched_go,
  input  logic [6:0]        cfg_vld_data_size,
  input  logic [FRAC_W-1:0] cfg_vld_frac,
  output logic              sched_stream_en,
  output logic [1:0]        sched_stream_state,
  output logic              sched_main_rd,
  output logic              sched_tu_start,
  output logic              sched_busy
);
  import dp_sched_pkg::*;

  localparam logic [5:0] POS_LAST = 6'(TU_SIZE - 1);

  sched_fsm_t    state_q, state_d;
  logic [5:0]    pos_q, pos_d;
  logic          start;
  logic          acc_clear;
  logic [6:0]    n_tu;
  stream_state_t ss_d;
  logic [1:0]    ss_q;
  logic          en_q, rd_q, start_q;

  function automatic sched_fsm_t slot_of(input logic [5:0] pos, input logic [6:0] n);
    if ({1'b0, pos} < n) begin
      return ST_DATA;
    end else if (pos == POS_LAST) begin
      return ST_FE;
    end else if ({1'b0, pos} == n) begin
      return ST_FS;
    end else begin
      return ST_STUFF;
    end
  endfunction

  // Position 0 is always DATA (N >= 1), so the N latched at the start edge
  // is first needed one cycle later.
  tu_frac_accum #(.FRAC_W(FRAC_W)) u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (acc_clear),
    .advance_i (start),
    .size_i    (cfg_vld_data_size),
    .frac_i    (cfg_vld_frac),
    .n_o       (n_tu)
  );

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    start     = 1'b0;
    acc_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sched_go) begin
          start     = 1'b1;
          acc_clear = 1'b1;
          pos_d     = '0;
          state_d   = ST_DATA;
        end
      end
      default: begin
        if (pos_q == POS_LAST) begin
          pos_d = '0;
          if (sched_go) begin
            start   = 1'b1;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          pos_d   = pos_q + 6'd1;
          state_d = slot_of(pos_d, n_tu);
        end
      end
    endcase
  end

  always_comb begin
    ss_d = SS_STUFF;
    case (state_d)
      ST_DATA: ss_d = SS_DATA;
      ST_FS:   ss_d = SS_FS;
      ST_FE:   ss_d = SS_FE;
      default: ss_d = SS_STUFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      en_q    <= 1'b0;
      ss_q    <= SS_STUFF;
      rd_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      en_q    <= (state_d != ST_IDLE);
      ss_q    <= ss_d;
      rd_q    <= (state_d == ST_DATA);
      start_q <= start;
    end
  end

  assign sched_stream_en    = en_q;
  assign sched_stream_state = ss_q;
  assign sched_main_rd      = rd_q;
  assign sched_tu_start     = start_q;
  assign sched_busy         = en_q;

endmodule

// File: tb/tb_stream_scheduler.sv
// Scoreboard bench for stream_scheduler: a TU model queues expected slots,
// a negedge monitor pops and compares every active slot.
module tb_stream_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic [6:0] cfg_size = 7'd60;
  logic [3:0] cfg_frac = 4'd0;
  logic       en, rd, start, busy;
  logic [1:0] st;

  typedef struct packed {
    logic       en;
    logic [1:0] st;
    logic       rd;
    logic       start;
    logic       busy;
  } slot_t;

  slot_t q[$];
  slot_t exp_s;
  int    n_checks = 0;
  int    n_err = 0;
  int    rd_cnt = 0;
  int    acc_m = 0;

  stream_scheduler #(.TU_SIZE(64), .FRAC_W(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sched_go           (go),
    .cfg_vld_data_size  (cfg_size),
    .cfg_vld_frac       (cfg_frac),
    .sched_stream_en    (en),
    .sched_stream_state (st),
    .sched_main_rd      (rd),
    .sched_tu_start     (start),
    .sched_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model one TU: push 64 expected slots, return its data count.
  task automatic push_tu(input int size, input int frac, output int n);
    int sum, sz;
    logic [1:0] s;
    sum   = acc_m + frac;
    acc_m = sum % 16;
    sz    = (size == 0) ? 1 : (size > 64) ? 64 : size;
    n     = sz + sum / 16;
    if (n > 64) n = 64;
    for (int p = 0; p < 64; p++) begin
      if (p < n) s = 2'b10;
      else if (p == 63) s = 2'b01;
      else if (p == n) s = 2'b00;
      else s = 2'b11;
      q.push_back('{en: 1'b1, st: s, rd: (p < n), start: (p == 0), busy: 1'b1});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && en) begin
      if (rd) rd_cnt++;
      if (q.size() == 0) begin
        chk("sb_unexpected_slot", en, 1'b0);
      end else begin
        exp_s = q.pop_front();
        chk("slot", {en, st, rd, start, busy}, exp_s);
      end
    end
  end

  // Run ntus TUs from IDLE; drop_at >= 0 drops go at that pos of a single TU.
  task automatic run_tus(input int size, input int frac, input int ntus, input int drop_at);
    int n, nsum, rd0;
    nsum  = 0;
    acc_m = 0;
    cfg_size = 7'(size);
    cfg_frac = 4'(frac);
    for (int t = 0; t < ntus; t++) begin
      push_tu(size, frac, n);
      nsum += n;
    end
    @(negedge clk);
    go  = 1'b1;
    rd0 = rd_cnt;
    @(negedge clk);
    chk("start_latency", {en, start}, 2'b11);
    if (drop_at >= 0) begin
      repeat (drop_at) @(negedge clk);
      go = 1'b0;
      cfg_size = 7'd1;
      cfg_frac = 4'd15;
      repeat (63 - drop_at) @(negedge clk);
    end else begin
      repeat (64 * ntus - 1) @(negedge clk);
      go = 1'b0;
    end
    @(negedge clk);
    chk("idle_after_tu", {en, busy, rd}, 3'b000);
    chk("sb_drained", q.size(), 0);
    chk("rd_total", rd_cnt - rd0, nsum);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_en", en, 1'b0);
    chk("rst_state", st, 2'b11);
    chk("rst_rd", rd, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_go", en, 1'b0);

    run_tus(60, 0, 3, -1);
    run_tus(63, 0, 1, -1);
    run_tus(62, 0, 1, -1);
    run_tus(64, 5, 2, -1);
    run_tus(0, 0, 1, -1);
    run_tus(100, 0, 1, -1);
    run_tus(40, 8, 16, -1);
    chk("rd_total_40_8", rd_cnt >= 648, 1'b1);
    run_tus(40, 8, 1, -1);
    run_tus(40, 8, 1, 20);
    run_tus(40, 8, 2, -1);

    // Asynchronous reset in the middle of a TU.
    cfg_size = 7'd40;
    cfg_frac = 4'd8;
    acc_m = 0;
    begin
      int n;
      push_tu(40, 8, n);
    end
    @(negedge clk);
    go = 1'b1;
    repeat (31) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_en", en, 1'b0);
    chk("rst_mid_state", st, 2'b11);
    chk("rst_mid_rd", rd, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    q.delete();
    acc_m = 0;
    begin
      int n;
      push_tu(40, 8, n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_restart_latency", {en, start}, 2'b11);
    repeat (63) @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("rst_restart_idle", en, 1'b0);
    chk("rst_restart_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
